sample_stream_tx: RTL



---
 rtl/sample_stream_tx.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sample_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : sample_stream_tx
//  Description : Captures DEPTH records of NUM_CH ADC channel samples into an
//                internal buffer, then streams each record as tagged 5-bit
//                payload bytes to a JTAG UART Avalon write port. Each record
//                waits for a host ACK. A NACK or an ack timeout triggers a
//                retransmit, and exhausting MAX_RETRY reports a sticky error.
//                Optional macro SAMPLE_STREAM_TX_CHECKSUM_EN appends an XOR
//                checksum byte (tag 3'b110) to every record.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module sample_stream_tx #(
    parameter int SAMPLE_W    = 10,
    parameter int NUM_CH      = 2,
    parameter int DEPTH       = 128,
    parameter int ACK_TIMEOUT = 50000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
    output logic                       tx_write,
    output logic [7:0]                 tx_data,
    input  logic                       tx_waitrequest,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [$clog2(DEPTH)-1:0]   record_idx
);

    localparam int CHUNKS = (SAMPLE_W + 4) / 5;
    localparam int PAD_W  = CHUNKS * 5;
    localparam int REC_W  = NUM_CH * SAMPLE_W;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CK_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int TMO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_REC = IDX_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CK_W-1:0]  LAST_CK  = CK_W'(CHUNKS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURE  = 3'd1,
        ST_SEND     = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic [REC_W-1:0] rec_mem [DEPTH];
    logic [REC_W-1:0] cur_rec;

    logic [CH_W-1:0]  ch_cnt;
    logic [CK_W-1:0]  chunk_cnt;
    logic [TMO_W-1:0] timer;
    logic [RTY_W-1:0] retry;

    logic [NUM_CH-1:0][CHUNKS-1:0][4:0] chunk_tab;
    logic [PAD_W-1:0] padded;
    logic [2:0]       tag;
    logic [7:0]       cur_byte;

    logic accept;
    logic last_data;
    logic last_byte;
    logic is_ack;
    logic is_nack;
    logic timeout;
    logic unused_rx;

`ifdef SAMPLE_STREAM_TX_CHECKSUM_EN
    logic       cks_phase;
    logic [4:0] cks;
`endif

    assign cur_rec   = rec_mem[record_idx];
    assign accept    = tx_write & ~tx_waitrequest;
    assign last_data = (ch_cnt == LAST_CH) && (chunk_cnt == LAST_CK);
`ifdef SAMPLE_STREAM_TX_CHECKSUM_EN
    assign last_byte = cks_phase;
`else
    assign last_byte = last_data;
`endif
    // Only the two class bits of a host byte carry meaning here.
    assign is_ack    = rx_valid && (rx_data[7:6] == 2'b10);
    assign is_nack   = rx_valid && (rx_data[7:6] == 2'b11);
    assign unused_rx = ^rx_data[5:0];
    assign timeout   = (timer == TMO_LAST);
    assign busy      = (state == ST_CAPTURE) || (state == ST_SEND) || (state == ST_WAIT_ACK);
    // tx_data reads as zero whenever no write is being requested.
    assign tx_data   = tx_write ? cur_byte : 8'h00;

    // Split the current record into zero-padded 5-bit chunks (and their XOR).
    always_comb begin
        chunk_tab = '0;
        padded    = '0;
`ifdef SAMPLE_STREAM_TX_CHECKSUM_EN
        cks       = '0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            padded = '0;
            padded[SAMPLE_W-1:0] = cur_rec[c*SAMPLE_W +: SAMPLE_W];
            for (int j = 0; j < CHUNKS; j++) begin
                chunk_tab[c][j] = padded[j*5 +: 5];
`ifdef SAMPLE_STREAM_TX_CHECKSUM_EN
                cks = cks ^ padded[j*5 +: 5];
`endif
            end
        end
    end

    // Assemble the outgoing byte: tag header over the selected payload chunk.
    always_comb begin
        tag      = (chunk_cnt == LAST_CK) ? 3'b111 : {1'b0, 2'(chunk_cnt)};
        cur_byte = {tag, chunk_tab[ch_cnt][chunk_cnt]};
`ifdef SAMPLE_STREAM_TX_CHECKSUM_EN
        if (cks_phase) begin
            cur_byte = {3'b110, cks};
        end
`endif
    end

    // Capture buffer; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (state == ST_CAPTURE && sample_valid) begin
            rec_mem[record_idx] <= sample_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; ACK takes priority over NACK and timeout.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_ERROR: begin
                if (start) next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (sample_valid && record_idx == LAST_REC) next_state = ST_SEND;
            end
            ST_SEND: begin
                if (accept && last_byte) next_state = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (is_ack) begin
                    next_state = (record_idx == LAST_REC) ? ST_IDLE : ST_SEND;
                end else if (is_nack || timeout) begin
                    next_state = (retry == RTY_LAST) ? ST_ERROR : ST_SEND;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Datapath: record index, byte counters, write strobe, ack timer, retries.
    always_ff @(posedge clk) begin
        if (reset) begin
            record_idx <= '0;
            ch_cnt     <= '0;
            chunk_cnt  <= '0;
            tx_write   <= 1'b0;
            timer      <= '0;
            retry      <= '0;
            error      <= 1'b0;
            done       <= 1'b0;
`ifdef SAMPLE_STREAM_TX_CHECKSUM_EN
            cks_phase  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_ERROR: begin
                    if (start) begin
                        record_idx <= '0;
                        retry      <= '0;
                        error      <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid) begin
                        record_idx <= (record_idx == LAST_REC) ? '0 : record_idx + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (!tx_write) begin
                        tx_write <= 1'b1;
                    end else if (accept) begin
                        if (last_byte) begin
                            tx_write  <= 1'b0;
                            ch_cnt    <= '0;
                            chunk_cnt <= '0;
                            timer     <= '0;
`ifdef SAMPLE_STREAM_TX_CHECKSUM_EN
                            cks_phase <= 1'b0;
                        end else if (last_data) begin
                            cks_phase <= 1'b1;
`endif
                        end else if (chunk_cnt == LAST_CK) begin
                            chunk_cnt <= '0;
                            ch_cnt    <= ch_cnt + 1'b1;
                        end else begin
                            chunk_cnt <= chunk_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (is_ack) begin
                        retry <= '0;
                        if (record_idx == LAST_REC) begin
                            record_idx <= '0;
                            done       <= 1'b1;
                        end else begin
                            record_idx <= record_idx + 1'b1;
                        end
                    end else if (is_nack || timeout) begin
                        if (retry == RTY_LAST) begin
                            error <= 1'b1;
                        end else begin
                            retry <= retry + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
